// File: rtl/ramm_pkg.sv
// Shared sizing constants and word type for the 16x8 scratch RAM.
package ramm_pkg;

  localparam int unsigned RAMM_DATA_W = 8;
  localparam int unsigned RAMM_ADDR_W = 4;
  localparam int unsigned RAMM_DEPTH  = 1 << RAMM_ADDR_W;

  typedef logic [RAMM_DATA_W-1:0] word_t;

endpackage

// File: rtl/ramm_array.sv
// Flop-based storage array: synchronous clear, single write port, combinational read mux.
module ramm_array
  import ramm_pkg::*;
#(
  parameter int unsigned DATA_W = RAMM_DATA_W,
  parameter int unsigned ADDR_W = RAMM_ADDR_W,
  parameter int unsigned DEPTH  = RAMM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Clear wins over write so a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[addr] <= din;
    end
  end

  assign rd_data = mem_q[addr];

endmodule

// File: rtl/ramm_16x8.sv
// 16x8 single-port RAM with registered, write-first read data.
module ramm_16x8
  import ramm_pkg::*;
#(
  parameter int unsigned DATA_W = RAMM_DATA_W,
  parameter int unsigned ADDR_W = RAMM_ADDR_W,
  parameter int unsigned DEPTH  = RAMM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] dout_d;
  logic [DATA_W-1:0] dout_q;

  ramm_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .addr    (addr),
    .din     (din),
    .rd_data (rd_data)
  );

  // Write-first: on a write edge the new word appears on dout directly.
  always_comb begin
    dout_d = wr_en ? din : rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_ramm_16x8.sv
// Self-checking bench for ramm_16x8: directed plan plus randomized traffic against an array model.
module tb_ramm_16x8;
  import ramm_pkg::*;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  int checks;
  int failures;

  // Reference model: plain array of words plus the expected dout after each edge.
  word_t ref_mem [16];
  word_t exp_dout;
  bit    model_valid;

  ramm_16x8 dut (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .addr  (addr),
    .din   (din),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      foreach (ref_mem[i]) ref_mem[i] = '0;
      exp_dout    = '0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (wr_en) begin
        ref_mem[addr] = din;
        exp_dout      = din;
      end else begin
        exp_dout = ref_mem[addr];
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (dout !== exp_dout) begin
        failures++;
        $display("FAIL model_cmp t=%0t dout=%02h expected=%02h", $time, dout, exp_dout);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] want);
    checks++;
    if (dout !== want) begin
      failures++;
      $display("FAIL %s t=%0t dout=%02h expected=%02h", name, $time, dout, want);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    rst   = r;
    wr_en = w;
    addr  = a;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t bench did not finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    checks      = 0;
    failures    = 0;
    model_valid = 1'b0;
    exp_dout    = '0;
    rst   = 1'b0;
    wr_en = 1'b0;
    addr  = '0;
    din   = '0;

    // Reset clear
    step(1'b1, 1'b1, 4'd3, 8'h5A);
    chk("reset_dout", 8'h00);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 4'(i), 8'($urandom));
      chk("reset_clear", 8'h00);
    end

    // Write/readback with write-through
    step(1'b0, 1'b1, 4'd0, 8'h08);
    chk("wr_through_0", 8'h08);
    step(1'b0, 1'b1, 4'd2, 8'h06);
    chk("wr_through_2", 8'h06);
    step(1'b0, 1'b0, 4'd0, 8'h00);
    chk("readback_0", 8'h08);
    step(1'b0, 1'b0, 4'd2, 8'h00);
    chk("readback_2", 8'h06);

    // Untouched words, din ignored on reads
    step(1'b0, 1'b0, 4'd1, 8'h07);
    chk("untouched_1", 8'h00);
    step(1'b0, 1'b0, 4'd3, 8'h01);
    chk("untouched_3", 8'h00);
    step(1'b0, 1'b0, 4'd1, 8'h00);
    chk("read_ignores_din", 8'h00);

    // Overwrite
    step(1'b0, 1'b1, 4'd5, 8'hA5);
    chk("overwrite_a", 8'hA5);
    step(1'b0, 1'b1, 4'd5, 8'h3C);
    chk("overwrite_b", 8'h3C);
    step(1'b0, 1'b0, 4'd5, 8'h00);
    chk("overwrite_rd", 8'h3C);

    // Reset mid-operation drops the concurrent write
    for (int i = 0; i < 16; i++) begin
      v = 8'(i) ^ 8'hF0;
      step(1'b0, 1'b1, 4'(i), v);
      chk("fill_through", v);
    end
    step(1'b0, 1'b0, 4'd7, 8'h00);
    chk("fill_read_7", 8'hF7);
    step(1'b1, 1'b1, 4'd7, 8'hFF);
    chk("mid_reset_dout", 8'h00);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 4'(i), 8'h00);
      chk("mid_reset_clear", 8'h00);
    end

    // Full sweep: write addr*17, read back in reverse
    for (int i = 0; i < 16; i++) begin
      v = 8'(i * 17);
      step(1'b0, 1'b1, 4'(i), v);
      chk("sweep_wr", v);
    end
    for (int i = 15; i >= 0; i--) begin
      v = 8'(i * 17);
      step(1'b0, 1'b0, 4'(i), 8'($urandom));
      chk("sweep_rd", v);
    end

    // Randomized traffic, checked by the model process each cycle
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom), 4'($urandom), 8'($urandom));
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
